// File: rtl/mult_share_pkg.sv
// Shared definitions for the Q8.8 multiplier arbiter and its round-robin arbiter.
// Holds the default fixed-point geometry, the saturation limits and a helper
// that sizes requester ID fields.
package mult_share_pkg;

  localparam int Q_W    = 16;
  localparam int Q_FRAC = 8;

  typedef logic signed [Q_W-1:0] q8_8_t;

  localparam q8_8_t Q_MAX = 16'sh7FFF;
  localparam q8_8_t Q_MIN = 16'sh8000;

  // Width needed to hold a requester index; never less than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter.
// The first requester at or after the pointer (scanning upward with wrap) wins
// whenever the enable is high; the pointer then moves just past the winner.
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = id_width(N)
) (
  input  logic         clk_i,
  input  logic         rstN_i,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] winner;
  logic          found;

  // Scan from the pointer with wrap and pick the first active request
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    winner  = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
    if (en_i && found) grant_o[winner] = 1'b1;
  end

  // A grant always completes a transfer, so the pointer moves past the winner
  always_comb begin
    ptr_d = ptr_q;
    if (en_i && found) begin
      ptr_d = (winner == PW'(N - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Pointer register, cleared to requester 0 on reset
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mult_share_arb.sv
// One signed Q8.8 multiplier shared by NREQ requesters via round-robin.
// Two pipeline stages: operand register (s1) then result register.
// Optional macro MULT_SHARE_SAT_EN: when defined, overflowing products clamp to
// the most positive / most negative value; otherwise the low W bits wrap.
// Overflow is flagged on res_ovf in both builds.
module mult_share_arb
  import mult_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = Q_W,
  parameter int FRAC = Q_FRAC,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_data,
  output logic [IDW-1:0]    res_id,
  output logic              res_ovf
);

`ifdef MULT_SHARE_SAT_EN
  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
`endif

  logic                  s1Valid_q;
  logic signed [W-1:0]   s1A_q;
  logic signed [W-1:0]   s1B_q;
  logic [IDW-1:0]        s1Id_q;

  logic                  resValid_q;
  logic [W-1:0]          resData_q;
  logic [IDW-1:0]        resId_q;
  logic                  resOvf_q;

  logic                  s1Adv;
  logic                  canLoad;
  logic [NREQ-1:0]       grant;
  logic                  xfer;
  logic [W-1:0]          selA;
  logic [W-1:0]          selB;
  logic [IDW-1:0]        selId;

  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] quot;
  logic                  prodOvf;
  logic [W-1:0]          resData_d;

  // The result register frees up when empty or being drained; s1 may load
  // when it is empty or moving into the result register this cycle.
  assign s1Adv   = !resValid_q || res_ready;
  assign canLoad = !s1Valid_q || s1Adv;
  assign xfer    = |grant;

  assign req_ready = grant;
  assign res_valid = resValid_q;
  assign res_data  = resData_q;
  assign res_id    = resId_q;
  assign res_ovf   = resOvf_q;

  rr_arbiter #(
    .N  (NREQ),
    .PW (IDW)
  ) u_arb (
    .clk_i   (CLK),
    .rstN_i  (RST_N),
    .en_i    (canLoad),
    .req_i   (req_valid),
    .grant_o (grant)
  );

  // Route the granted requester's operands and index toward stage 1
  always_comb begin
    selA  = '0;
    selB  = '0;
    selId = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        selA  = req_a[i*W +: W];
        selB  = req_b[i*W +: W];
        selId = IDW'(i);
      end
    end
  end

  // Stage 1 holds its contents whenever the result register is stalled
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1Valid_q <= 1'b0;
      s1A_q     <= '0;
      s1B_q     <= '0;
      s1Id_q    <= '0;
    end else if (canLoad) begin
      s1Valid_q <= xfer;
      if (xfer) begin
        s1A_q  <= selA;
        s1B_q  <= selB;
        s1Id_q <= selId;
      end
    end
  end

  // Full-width signed product, rescaled by arithmetic shift (rounds toward
  // -inf); overflow whenever the bits above the result's sign bit disagree.
  always_comb begin
    prod    = $signed({{W{s1A_q[W-1]}}, s1A_q}) * $signed({{W{s1B_q[W-1]}}, s1B_q});
    quot    = prod >>> FRAC;
    prodOvf = (|quot[2*W-1:W-1]) && !(&quot[2*W-1:W-1]);
`ifdef MULT_SHARE_SAT_EN
    resData_d = prodOvf ? (quot[2*W-1] ? SAT_MIN : SAT_MAX) : quot[W-1:0];
`else
    resData_d = quot[W-1:0];
`endif
  end

  // Result register advances together with stage 1
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      resValid_q <= 1'b0;
      resData_q  <= '0;
      resId_q    <= '0;
      resOvf_q   <= 1'b0;
    end else if (s1Adv) begin
      resValid_q <= s1Valid_q;
      resData_q  <= resData_d;
      resId_q    <= s1Id_q;
      resOvf_q   <= prodOvf;
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed self-checking bench for mult_share_arb (default parameters).
// Expected products are hand-computed Q8.8 values; MULT_SHARE_SAT_EN selects
// the saturating or wrapping expectation for overflow cases.
module tb_mult_share_arb;
  import mult_share_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_data;
  logic [IDW-1:0]    res_id;
  logic              res_ovf;

  int nChecks = 0;
  int nFails  = 0;

  mult_share_arb dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ovf   (res_ovf)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task setOperand(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
  endtask

  task applyReset();
    RST_N = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Issue one operation from requester id and wait (bounded) for its result.
  task applyStimulus(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                     output logic [W-1:0] data, output logic [IDW-1:0] rid,
                     output logic ovf, output int latency, output logic accepted);
    @(negedge CLK);
    req_valid = '0;
    setOperand(id, a, b);
    req_valid[id] = 1'b1;
    #1 accepted = req_ready[id];
    @(posedge CLK);
    #1 req_valid = '0;
    latency = 0;
    data = '0;
    rid = '0;
    ovf = 1'b0;
    while (latency < 8) begin
      @(negedge CLK);
      latency++;
      if (res_valid) begin
        data = res_data;
        rid  = res_id;
        ovf  = res_ovf;
        break;
      end
    end
  endtask

  task test_reset();
    RST_N = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    repeat (2) @(negedge CLK);
    nChecks++; if (res_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b want 0", res_valid); end
    nChecks++; if (res_data !== 16'h0000) begin nFails++; $display("[TB] FAIL reset_data: got %h want 0000", res_data); end
    nChecks++; if (res_id !== 2'd0) begin nFails++; $display("[TB] FAIL reset_id: got %0d want 0", res_id); end
    nChecks++; if (res_ovf !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ovf: got %b want 0", res_ovf); end
    nChecks++; if (req_ready !== 4'b0000) begin nFails++; $display("[TB] FAIL reset_ready: got %b want 0000", req_ready); end
    RST_N = 1'b1;
    @(negedge CLK);
    req_valid = 4'b1111;
    #1;
    nChecks++; if (req_ready !== 4'b0001) begin nFails++; $display("[TB] FAIL reset_ptr: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task test_single_op();
    logic [W-1:0] d; logic [IDW-1:0] r; logic o; int lat; logic acc;
    applyStimulus(0, 16'h0400, 16'h0300, d, r, o, lat, acc);
    nChecks++; if (acc !== 1'b1) begin nFails++; $display("[TB] FAIL single_accept: got %b want 1", acc); end
    nChecks++; if (lat != 2) begin nFails++; $display("[TB] FAIL single_latency: got %0d want 2", lat); end
    nChecks++; if (d !== 16'h0C00) begin nFails++; $display("[TB] FAIL single_data: got %h want 0c00", d); end
    nChecks++; if (r !== 2'd0) begin nFails++; $display("[TB] FAIL single_id: got %0d want 0", r); end
    nChecks++; if (o !== 1'b0) begin nFails++; $display("[TB] FAIL single_ovf: got %b want 0", o); end
  endtask

  task test_sign();
    logic [W-1:0] d; logic [IDW-1:0] r; logic o; int lat; logic acc;
    applyStimulus(1, 16'hFC00, 16'h0300, d, r, o, lat, acc);
    nChecks++; if (d !== 16'hF400) begin nFails++; $display("[TB] FAIL sign_neg_data: got %h want f400", d); end
    nChecks++; if (r !== 2'd1) begin nFails++; $display("[TB] FAIL sign_neg_id: got %0d want 1", r); end
    nChecks++; if (o !== 1'b0) begin nFails++; $display("[TB] FAIL sign_neg_ovf: got %b want 0", o); end
    applyStimulus(2, 16'hFC00, 16'hFE00, d, r, o, lat, acc);
    nChecks++; if (d !== 16'h0800) begin nFails++; $display("[TB] FAIL sign_pos_data: got %h want 0800", d); end
    nChecks++; if (r !== 2'd2) begin nFails++; $display("[TB] FAIL sign_pos_id: got %0d want 2", r); end
  endtask

  task test_overflow();
    logic [W-1:0] d; logic [IDW-1:0] r; logic o; int lat; logic acc;
    logic [W-1:0] expPos, expNeg;
`ifdef MULT_SHARE_SAT_EN
    expPos = Q_MAX;
    expNeg = Q_MIN;
`else
    expPos = 16'hFE00;
    expNeg = 16'h0000;
`endif
    applyStimulus(3, 16'h7F00, 16'h0200, d, r, o, lat, acc);
    nChecks++; if (d !== expPos) begin nFails++; $display("[TB] FAIL ovf_pos_data: got %h want %h", d, expPos); end
    nChecks++; if (o !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_pos_flag: got %b want 1", o); end
    applyStimulus(0, 16'h8000, 16'h0200, d, r, o, lat, acc);
    nChecks++; if (d !== expNeg) begin nFails++; $display("[TB] FAIL ovf_neg_data: got %h want %h", d, expNeg); end
    nChecks++; if (o !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_neg_flag: got %b want 1", o); end
    applyStimulus(1, 16'h7F00, 16'h0100, d, r, o, lat, acc);
    nChecks++; if (d !== 16'h7F00 || o !== 1'b0) begin nFails++; $display("[TB] FAIL ovf_edge_max: got %h/%b want 7f00/0", d, o); end
    applyStimulus(2, 16'h8000, 16'h0100, d, r, o, lat, acc);
    nChecks++; if (d !== 16'h8000 || o !== 1'b0) begin nFails++; $display("[TB] FAIL ovf_edge_min: got %h/%b want 8000/0", d, o); end
  endtask

  task test_truncation();
    logic [W-1:0] d; logic [IDW-1:0] r; logic o; int lat; logic acc;
    applyStimulus(3, 16'hFFFF, 16'h0080, d, r, o, lat, acc);
    nChecks++; if (d !== 16'hFFFF || o !== 1'b0) begin nFails++; $display("[TB] FAIL trunc_neg: got %h/%b want ffff/0", d, o); end
    applyStimulus(0, 16'h0001, 16'h0080, d, r, o, lat, acc);
    nChecks++; if (d !== 16'h0000 || o !== 1'b0) begin nFails++; $display("[TB] FAIL trunc_pos: got %h/%b want 0000/0", d, o); end
  endtask

  task test_back_to_back();
    logic [W-1:0] expData;
    applyReset();
    @(negedge CLK);
    for (int i = 0; i < NREQ; i++) setOperand(i, 16'((i + 1) * 256), 16'h0100);
    req_valid = 4'b1111;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge CLK);
      if (cyc >= 1) begin
        expData = 16'((((cyc - 1) % NREQ) + 1) * 256);
        nChecks++; if (res_valid !== 1'b1) begin nFails++; $display("[TB] FAIL rr_valid[%0d]: got %b want 1", cyc, res_valid); end
        nChecks++; if (res_id !== IDW'((cyc - 1) % NREQ)) begin nFails++; $display("[TB] FAIL rr_id[%0d]: got %0d want %0d", cyc, res_id, (cyc - 1) % NREQ); end
        nChecks++; if (res_data !== expData) begin nFails++; $display("[TB] FAIL rr_data[%0d]: got %h want %h", cyc, res_data, expData); end
      end
    end
    req_valid = '0;
    repeat (4) @(negedge CLK);
  endtask

  task test_backpressure();
    applyReset();
    @(negedge CLK);
    res_ready = 1'b0;
    setOperand(0, 16'h0200, 16'h0300);
    setOperand(1, 16'h0100, 16'hFF00);
    setOperand(2, 16'h0080, 16'h0400);
    req_valid = 4'b0011;
    #1;
    nChecks++; if (req_ready !== 4'b0001) begin nFails++; $display("[TB] FAIL bp_ready0: got %b want 0001", req_ready); end
    @(posedge CLK);
    #1 req_valid = 4'b0010;
    @(negedge CLK);
    nChecks++; if (req_ready !== 4'b0010) begin nFails++; $display("[TB] FAIL bp_ready1: got %b want 0010", req_ready); end
    @(posedge CLK);
    #1 req_valid = 4'b0100;
    for (int s = 0; s < 5; s++) begin
      @(negedge CLK);
      nChecks++; if (req_ready !== 4'b0000) begin nFails++; $display("[TB] FAIL bp_stall_ready[%0d]: got %b want 0000", s, req_ready); end
      nChecks++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 16'h0600) begin
        nFails++; $display("[TB] FAIL bp_stall_hold[%0d]: got v=%b id=%0d d=%h want v=1 id=0 d=0600", s, res_valid, res_id, res_data);
      end
    end
    res_ready = 1'b1;
    #1;
    nChecks++; if (req_ready !== 4'b0100) begin nFails++; $display("[TB] FAIL bp_release_ready: got %b want 0100", req_ready); end
    @(posedge CLK);
    #1 req_valid = '0;
    @(negedge CLK);
    nChecks++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 16'hFF00) begin
      nFails++; $display("[TB] FAIL bp_drain1: got v=%b id=%0d d=%h want v=1 id=1 d=ff00", res_valid, res_id, res_data);
    end
    @(negedge CLK);
    nChecks++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== 16'h0200) begin
      nFails++; $display("[TB] FAIL bp_drain2: got v=%b id=%0d d=%h want v=1 id=2 d=0200", res_valid, res_id, res_data);
    end
    @(negedge CLK);
    nChecks++; if (res_valid !== 1'b0) begin nFails++; $display("[TB] FAIL bp_empty: got %b want 0", res_valid); end
  endtask

  task test_reset_mid();
    int lat;
    applyReset();
    @(negedge CLK);
    res_ready = 1'b0;
    setOperand(0, 16'h0200, 16'h0300);
    setOperand(1, 16'h0100, 16'hFF00);
    req_valid = 4'b0011;
    @(posedge CLK);
    #1 req_valid = 4'b0010;
    @(posedge CLK);
    #1 req_valid = '0;
    #1;
    nChecks++; if (res_valid !== 1'b1) begin nFails++; $display("[TB] FAIL rmid_pre_valid: got %b want 1", res_valid); end
    RST_N = 1'b0;
    #1;
    nChecks++; if (res_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rmid_valid: got %b want 0", res_valid); end
    nChecks++; if (res_data !== 16'h0000 || res_id !== 2'd0 || res_ovf !== 1'b0) begin
      nFails++; $display("[TB] FAIL rmid_outputs: got d=%h id=%0d o=%b want 0000/0/0", res_data, res_id, res_ovf);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    res_ready = 1'b1;
    setOperand(1, 16'h0300, 16'h0500);
    setOperand(3, 16'h0100, 16'h0100);
    req_valid = 4'b1010;
    #1;
    nChecks++; if (req_ready !== 4'b0010) begin nFails++; $display("[TB] FAIL rmid_ptr: got %b want 0010", req_ready); end
    @(posedge CLK);
    #1 req_valid = '0;
    lat = 0;
    while (lat < 8) begin
      @(negedge CLK);
      lat++;
      if (res_valid) break;
    end
    nChecks++; if (lat != 2) begin nFails++; $display("[TB] FAIL rmid_latency: got %0d want 2", lat); end
    nChecks++; if (res_data !== 16'h0F00 || res_id !== 2'd1) begin
      nFails++; $display("[TB] FAIL rmid_result: got d=%h id=%0d want 0f00/1", res_data, res_id);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_sign();
    test_overflow();
    test_truncation();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
